// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and architectural register file.
//
// This block takes the registered MEM/WB bundle and picks the write-back value. It
// commits that value to the GPR array, serves the two ID-stage read ports, and
// counts the register writes that actually commit.
//
// Ports:
//   clk_i       clock; all state changes on posedge
//   rst_i       asynchronous reset, active low
//   WB_i        [1]=RegWrite, [0]=MemtoReg
//   addr_i      ALU result from MEM/WB
//   data_i      memory load data from MEM/WB
//   rd_i        destination register index
//   rs_addr_i   read port A index
//   rt_addr_i   read port B index
//   rs_data_o   read port A data (combinational)
//   rt_data_o   read port B data (combinational)
//   wb_data_o   selected write-back value (combinational, feeds EX forwarding)
//   wb_count_o  number of committed register writes (wraps silently)
//
// Build option:
//   WB_BYPASS_EN  when defined, a read of the register being written in the same
//                 cycle returns wb_data_o before the clock edge (write-through).
//                 When undefined, reads return only stored contents, so a read in
//                 the same cycle as the write sees the old value.

module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        WB_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [AW-1:0]     rd_i,
  input  logic [AW-1:0]     rs_addr_i,
  input  logic [AW-1:0]     rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [CNT_W-1:0]  wb_count_o
);

  logic [DATA_W-1:0] gpr_q [NREG];
  logic [CNT_W-1:0]  wb_count_q;
  logic              we;

  // Write-back mux is independent of RegWrite so forwarding always sees it.
  assign wb_data_o = WB_i[0] ? data_i : addr_i;

  // r0 is hardwired to zero: a write to it is dropped and is not counted.
  assign we = WB_i[1] && (rd_i != '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        gpr_q[i] <= '0;
      end
      wb_count_q <= '0;
    end else if (we) begin
      gpr_q[rd_i] <= wb_data_o;
      wb_count_q  <= wb_count_q + 1'b1;
    end
  end

  assign wb_count_o = wb_count_q;

  always_comb begin
    rs_data_o = (rs_addr_i == '0) ? '0 : gpr_q[rs_addr_i];
    rt_data_o = (rt_addr_i == '0) ? '0 : gpr_q[rt_addr_i];
`ifdef WB_BYPASS_EN
    // we already excludes rd_i==0, so r0 can never be bypassed.
    if (we && (rs_addr_i == rd_i)) begin
      rs_data_o = wb_data_o;
    end
    if (we && (rt_addr_i == rd_i)) begin
      rt_data_o = wb_data_o;
    end
`else
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: self-checking bench for wb_regfile.
// It uses a vector table with a scoreboard queue for post-edge read-back. Hand-written
// sequences cover the same-cycle hazard, counter wrap and asynchronous reset. The
// counter is built narrow (CNT_W=8), so the wrap is reached in a few hundred cycles.

module tb_wb_regfile;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        wb;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [4:0]        rd;
  logic [4:0]        rs_addr;
  logic [4:0]        rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]  wb_count;

  wb_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .WB_i       (wb),
    .addr_i     (addr),
    .data_i     (data),
    .rd_i       (rd),
    .rs_addr_i  (rs_addr),
    .rt_addr_i  (rt_addr),
    .rs_data_o  (rs_data),
    .rt_data_o  (rt_data),
    .wb_data_o  (wb_data),
    .wb_count_o (wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       wb;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [4:0]       rd;
    logic [31:0]      exp_wb;
    logic [31:0]      exp_val;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [4:0]       rd;
    logic [31:0]      val;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] r);
    wb   = w;
    addr = a;
    data = d;
    rd   = r;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   cnt_model;

    // Inputs are driven and outputs sampled 1-3 time units after posedge, away from both edges.
    vecs[0] = '{2'b10, 32'h0000_1234, 32'h0000_DEAD, 5'd5,  32'h0000_1234, 32'h0000_1234, 8'd1};
    vecs[1] = '{2'b11, 32'h0000_0000, 32'hCAFE_F00D, 5'd31, 32'hCAFE_F00D, 32'hCAFE_F00D, 8'd2};
    vecs[2] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0000, 5'd0,  32'hFFFF_FFFF, 32'h0000_0000, 8'd2};
    vecs[3] = '{2'b01, 32'h0000_0011, 32'h0000_0077, 5'd7,  32'h0000_0077, 32'h0000_0000, 8'd2};
    vecs[4] = '{2'b00, 32'h0000_0022, 32'h0000_0033, 5'd5,  32'h0000_0022, 32'h0000_1234, 8'd2};
    vecs[5] = '{2'b10, 32'hA5A5_A5A5, 32'h0000_0000, 5'd7,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 8'd3};
    vecs[6] = '{2'b11, 32'h0000_0001, 32'h1234_5678, 5'd5,  32'h1234_5678, 32'h1234_5678, 8'd4};
    vecs[7] = '{2'b10, 32'h8000_0000, 32'h0000_0001, 5'd1,  32'h8000_0000, 32'h8000_0000, 8'd5};
    vecs[8] = '{2'b11, 32'h0000_0000, 32'h0000_0000, 5'd0,  32'h0000_0000, 32'h0000_0000, 8'd5};

    rst     = 1'b0;
    drive(2'b10, 32'h1, 32'h2, 5'd5);  // write request held during reset must be ignored
    rs_addr = 5'd5;
    rt_addr = 5'd31;
    step();
    step();
    chk("reset_count", 32'(wb_count), 32'd0);
    chk("reset_rs", rs_data, 32'd0);
    chk("reset_rt", rt_data, 32'd0);
    drive(2'b00, 32'h0, 32'h0, 5'd0);
    rst = 1'b1;
    step();

    // Table vectors: check wb_data before the edge, then read back after it.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].wb, vecs[i].addr, vecs[i].data, vecs[i].rd);
      rs_addr = 5'd0;
      rt_addr = 5'd0;
      #1;
      chk($sformatf("vec%0d_wb_data", i), wb_data, vecs[i].exp_wb);
      sb.push_back('{vecs[i].rd, vecs[i].exp_val, vecs[i].exp_cnt});
      step();
      e  = sb.pop_front();
      wb = 2'b00;
      rs_addr = e.rd;
      rt_addr = e.rd;
      #1;
      chk($sformatf("vec%0d_rs", i), rs_data, e.val);
      chk($sformatf("vec%0d_rt", i), rt_data, e.val);
      chk($sformatf("vec%0d_count", i), 32'(wb_count), 32'(e.cnt));
    end

    // Earlier writes persist, and the two ports address different registers.
    rs_addr = 5'd31;
    rt_addr = 5'd7;
    #1;
    chk("persist_r31", rs_data, 32'hCAFE_F00D);
    chk("persist_r7", rt_data, 32'hA5A5_A5A5);
    step();

    // Same-cycle hazard on r9 with both ports pointed at it.
    drive(2'b10, 32'h0000_0055, 32'h0, 5'd9);
    rs_addr = 5'd9;
    rt_addr = 5'd9;
    #1;
`ifdef WB_BYPASS_EN
    chk("hazard_rs_pre", rs_data, 32'h55);
    chk("hazard_rt_pre", rt_data, 32'h55);
`else
    chk("hazard_rs_pre", rs_data, 32'h0);
    chk("hazard_rt_pre", rt_data, 32'h0);
`endif
    step();
    wb = 2'b00;
    #1;
    chk("hazard_rs_post", rs_data, 32'h55);
    chk("hazard_rt_post", rt_data, 32'h55);
    chk("hazard_count", 32'(wb_count), 32'd6);

    // Counter wrap: run up to the all-ones value, then one more write.
    cnt_model = 6;
    rs_addr = 5'd3;
    rt_addr = 5'd3;
    while (cnt_model < (2 ** CNT_W) - 1) begin
      drive(2'b10, 32'(cnt_model), 32'h0, 5'd3);
      step();
      cnt_model++;
    end
    wb = 2'b00;
    #1;
    chk("wrap_count_max", 32'(wb_count), 32'd255);
    chk("wrap_r3_last", rs_data, 32'd254);
    drive(2'b11, 32'h0, 32'hDEAD_0000, 5'd3);
    step();
    wb = 2'b00;
    #1;
    chk("wrap_count_zero", 32'(wb_count), 32'd0);
    chk("wrap_r3", rt_data, 32'hDEAD_0000);

    // Asynchronous reset mid-cycle, with a write request pending.
    step();
    drive(2'b10, 32'h0000_0099, 32'h0, 5'd4);
    rs_addr = 5'd3;
    rt_addr = 5'd31;
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_rs", rs_data, 32'd0);
    chk("async_rst_rt", rt_data, 32'd0);
    chk("async_rst_count", 32'(wb_count), 32'd0);
    step();
    rt_addr = 5'd4;
    #1;
    chk("rst_hold_r4", rt_data, 32'd0);
    chk("rst_hold_count", 32'(wb_count), 32'd0);
    wb  = 2'b00;
    rst = 1'b1;
    step();
    chk("post_rst_r4", rt_data, 32'd0);
    drive(2'b10, 32'h0000_0099, 32'h0, 5'd4);
    step();
    wb = 2'b00;
    #1;
    chk("post_rst_write_r4", rt_data, 32'h99);
    chk("post_rst_count", 32'(wb_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
